// File: rtl/vending_controller.sv
// Top-level vending sequencer: product selection, coin credit, dispense handshake
// and change/refund return. All outputs are registered or decoded from state.
module vending_controller #(
  parameter logic [4:0] PRODUCT_A_PRICE  = 5'd15,
  parameter logic [4:0] PRODUCT_B_PRICE  = 5'd20,
  parameter logic [4:0] PRODUCT_C_PRICE  = 5'd25,
  parameter logic [7:0] PAY_TIMEOUT      = 8'd200,
  parameter logic [7:0] DISPENSE_TIMEOUT = 8'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select_req,
  input  logic [1:0] product_sel,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       cancel,
  input  logic       product_selector_done,
  input  logic       product_dispense_done,
  output logic       signal_product_selector,
  output logic       product_dispense_en,
  output logic [1:0] selected_product,
  output logic [4:0] price,
  output logic [5:0] credit,
  output logic       coin_reject,
  output logic       change_valid,
  output logic [5:0] change_amount,
  output logic       dispense_error,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SELECT, PAY, DISPENSE, CHANGE} state_t;

  state_t     state, state_next;
  logic [7:0] timer, timer_next;
  logic [5:0] credit_next, change_amount_next;
  logic [4:0] price_next;
  logic [1:0] selected_next;
  logic       coin_reject_next, dispense_error_next;
  logic       coin_ok;
  logic [5:0] coin_amount, post_credit;

  function automatic logic [4:0] price_of(input logic [1:0] code);
    case (code)
      2'b01:   return PRODUCT_A_PRICE;
      2'b10:   return PRODUCT_B_PRICE;
      2'b11:   return PRODUCT_C_PRICE;
      default: return 5'd0;
    endcase
  endfunction

  // Credit including a coin arriving this cycle; only meaningful in PAY.
  assign coin_ok     = coin_valid && (coin_value == 2'b01 || coin_value == 2'b10);
  assign coin_amount = (coin_value == 2'b10) ? 6'd10 : 6'd5;
  assign post_credit = coin_ok ? credit + coin_amount : credit;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_next          = state;
    timer_next          = timer;
    credit_next         = credit;
    price_next          = price;
    selected_next       = selected_product;
    change_amount_next  = change_amount;
    coin_reject_next    = coin_valid;
    dispense_error_next = 1'b0;

    case (state)
      IDLE: begin
        if (select_req && product_sel != 2'b00) begin
          selected_next = product_sel;
          price_next    = price_of(product_sel);
          credit_next   = 6'd0;
          state_next    = SELECT;
        end
      end
      SELECT: begin
        if (cancel) begin
          change_amount_next = 6'd0;
          state_next         = CHANGE;
        end else if (product_selector_done) begin
          timer_next = 8'd0;
          state_next = PAY;
        end
      end
      PAY: begin
        coin_reject_next = coin_valid && !coin_ok;
        credit_next      = post_credit;
        if (post_credit >= {1'b0, price}) begin
          timer_next = 8'd0;
          state_next = DISPENSE;
        end else if (cancel) begin
          change_amount_next = post_credit;
          state_next         = CHANGE;
        end else if (coin_ok) begin
          timer_next = 8'd0;
        end else if (timer == PAY_TIMEOUT - 8'd1) begin
          change_amount_next = post_credit;
          state_next         = CHANGE;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      DISPENSE: begin
        // Entry is only taken with credit >= price, so this cannot underflow.
        if (product_dispense_done) begin
          change_amount_next = credit - {1'b0, price};
          state_next         = CHANGE;
        end else if (timer == DISPENSE_TIMEOUT - 8'd1) begin
          dispense_error_next = 1'b1;
          change_amount_next  = credit;
          state_next          = CHANGE;
        end else begin
          timer_next = timer + 8'd1;
        end
      end
      CHANGE: begin
        credit_next = 6'd0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      timer            <= 8'd0;
      credit           <= 6'd0;
      price            <= 5'd0;
      selected_product <= 2'b00;
      change_amount    <= 6'd0;
      coin_reject      <= 1'b0;
      dispense_error   <= 1'b0;
    end else begin
      state            <= state_next;
      timer            <= timer_next;
      credit           <= credit_next;
      price            <= price_next;
      selected_product <= selected_next;
      change_amount    <= change_amount_next;
      coin_reject      <= coin_reject_next;
      dispense_error   <= dispense_error_next;
    end
  end

  assign signal_product_selector = (state == SELECT);
  assign product_dispense_en     = (state == DISPENSE);
  assign change_valid            = (state == CHANGE);
  assign busy                    = (state != IDLE);

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed scenarios followed by
// randomized transactions scored against a transaction-level credit model.
module tb_vending_controller;

  localparam int PT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       select_req;
  logic [1:0] product_sel;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       cancel;
  logic       product_selector_done;
  logic       product_dispense_done;
  logic       signal_product_selector;
  logic       product_dispense_en;
  logic [1:0] selected_product;
  logic [4:0] price;
  logic [5:0] credit;
  logic       coin_reject;
  logic       change_valid;
  logic [5:0] change_amount;
  logic       dispense_error;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int m_credit;
  int m_price;
  int m_idle;

  vending_controller #(
    .PRODUCT_A_PRICE (5'd15),
    .PRODUCT_B_PRICE (5'd20),
    .PRODUCT_C_PRICE (5'd25),
    .PAY_TIMEOUT     (8'd4),
    .DISPENSE_TIMEOUT(8'd3)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .select_req             (select_req),
    .product_sel            (product_sel),
    .coin_valid             (coin_valid),
    .coin_value             (coin_value),
    .cancel                 (cancel),
    .product_selector_done  (product_selector_done),
    .product_dispense_done  (product_dispense_done),
    .signal_product_selector(signal_product_selector),
    .product_dispense_en    (product_dispense_en),
    .selected_product       (selected_product),
    .price                  (price),
    .credit                 (credit),
    .coin_reject            (coin_reject),
    .change_valid           (change_valid),
    .change_amount          (change_amount),
    .dispense_error         (dispense_error),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int price_model(input int code);
    case (code)
      1: return 15;
      2: return 20;
      3: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int coin_worth(input logic [1:0] v);
    if (v == 2'b01) return 5;
    if (v == 2'b10) return 10;
    return 0;
  endfunction

  task automatic clear_inputs();
    select_req = 0; product_sel = 0; coin_valid = 0; coin_value = 0;
    cancel = 0; product_selector_done = 0; product_dispense_done = 0;
  endtask

  task automatic finish_change();
    tick();
    check("post_change_busy", busy, 0);
    check("post_change_valid", change_valid, 0);
    check("post_change_credit", credit, 0);
    check("post_change_err", dispense_error, 0);
    check("post_change_reject", coin_reject, 0);
  endtask

  task automatic start(input int p);
    select_req = 1; product_sel = p[1:0];
    tick();
    select_req = 0; product_sel = 0;
    m_price = price_model(p); m_credit = 0; m_idle = 0;
    check("sel_signal", signal_product_selector, 1);
    check("sel_busy", busy, 1);
    check("sel_product", selected_product, p);
    check("sel_price", price, m_price);
    check("sel_credit", credit, 0);
  endtask

  // Returns 1 when the selector acked (now in PAY), 0 when cancelled.
  task automatic handshake(input int wait_c, input bit cxl, output bit in_pay);
    for (int i = 0; i < wait_c; i++) begin
      tick();
      check("sel_hold", signal_product_selector, 1);
    end
    if (cxl) begin
      cancel = 1; product_selector_done = 1'($urandom_range(0, 1));
      tick();
      clear_inputs();
      check("sel_cancel_valid", change_valid, 1);
      check("sel_cancel_amount", change_amount, 0);
      check("sel_cancel_signal", signal_product_selector, 0);
      finish_change();
      in_pay = 0;
    end else begin
      product_selector_done = 1;
      tick();
      clear_inputs();
      check("pay_entry_signal", signal_product_selector, 0);
      check("pay_entry_busy", busy, 1);
      in_pay = 1;
    end
  endtask

  // One PAY cycle; outcome 0 = still paying, 1 = dispensing, 2 = refunding.
  task automatic pay_cycle(input bit coin_on, input logic [1:0] v, input bit cxl,
                           output int outcome);
    bit accepted;
    coin_valid = coin_on; coin_value = v; cancel = cxl;
    tick();
    clear_inputs();
    accepted = coin_on && coin_worth(v) != 0;
    if (accepted) begin
      m_credit += coin_worth(v);
      m_idle = 0;
    end else begin
      m_idle++;
    end
    if (m_credit >= m_price) outcome = 1;
    else if (cxl) outcome = 2;
    else if (m_idle == PT) outcome = 2;
    else outcome = 0;
    check("pay_reject", coin_reject, coin_on && !accepted);
    case (outcome)
      0: begin
        check("pay_credit", credit, m_credit);
        check("pay_en", product_dispense_en, 0);
        check("pay_change", change_valid, 0);
      end
      1: begin
        check("disp_credit", credit, m_credit);
        check("disp_en", product_dispense_en, 1);
      end
      default: begin
        check("refund_valid", change_valid, 1);
        check("refund_amount", change_amount, m_credit);
        check("refund_en", product_dispense_en, 0);
      end
    endcase
  endtask

  task automatic dispense_phase(input int wait_c, input bit noise);
    int n;
    bit c;
    n = (wait_c < DT) ? wait_c : DT - 1;
    for (int i = 0; i < n; i++) begin
      c = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      coin_valid = c; coin_value = 2'($urandom_range(1, 2));
      cancel = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      clear_inputs();
      check("disp_hold_en", product_dispense_en, 1);
      check("disp_hold_err", dispense_error, 0);
      check("disp_hold_change", change_valid, 0);
      check("disp_coin_reject", coin_reject, c);
      check("disp_hold_credit", credit, m_credit);
    end
    if (wait_c < DT) begin
      product_dispense_done = 1;
      tick();
      clear_inputs();
      check("done_change_valid", change_valid, 1);
      check("done_change_amount", change_amount, m_credit - m_price);
      check("done_err", dispense_error, 0);
      check("done_en", product_dispense_en, 0);
    end else begin
      tick();
      check("tmo_err", dispense_error, 1);
      check("tmo_change_valid", change_valid, 1);
      check("tmo_change_amount", change_amount, m_credit);
      check("tmo_en", product_dispense_en, 0);
    end
    finish_change();
  endtask

  initial begin
    bit in_pay;
    int outcome;
    int p;
    int r;
    clear_inputs();

    // Reset state
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_credit", credit, 0);
    check("rst_price", price, 0);
    check("rst_product", selected_product, 0);
    check("rst_change", change_amount, 0);
    check("rst_sig", signal_product_selector, 0);

    // Exact pay with product B
    start(2);
    handshake(1, 0, in_pay);
    pay_cycle(1, 2'b10, 0, outcome);
    pay_cycle(1, 2'b10, 0, outcome);
    check("exact_outcome_en", product_dispense_en, 1);
    dispense_phase(1, 0);
    check("exact_product", selected_product, 2);

    // Overpay with product A
    start(1);
    handshake(0, 0, in_pay);
    pay_cycle(1, 2'b10, 0, outcome);
    pay_cycle(1, 2'b10, 0, outcome);
    check("over_credit", credit, 20);
    dispense_phase(0, 0);

    // Cancel with same-cycle coin on product C
    start(3);
    handshake(2, 0, in_pay);
    pay_cycle(1, 2'b10, 0, outcome);
    pay_cycle(1, 2'b01, 1, outcome);
    check("cancel_amount", change_amount, 15);
    finish_change();

    // Invalid coin in PAY, then IDLE coin
    start(1);
    handshake(0, 0, in_pay);
    pay_cycle(1, 2'b01, 0, outcome);
    pay_cycle(1, 2'b11, 0, outcome);
    pay_cycle(0, 2'b00, 1, outcome);
    finish_change();
    coin_valid = 1; coin_value = 2'b10;
    tick();
    clear_inputs();
    check("idle_coin_reject", coin_reject, 1);
    check("idle_coin_busy", busy, 0);

    // Pay timeout: one coin of 5 then silence
    start(1);
    handshake(0, 0, in_pay);
    pay_cycle(1, 2'b01, 0, outcome);
    for (int i = 0; i < PT; i++) pay_cycle(0, 2'b00, 0, outcome);
    check("pay_tmo_amount", change_amount, 5);
    finish_change();

    // Dispense timeout
    start(3);
    handshake(0, 0, in_pay);
    pay_cycle(1, 2'b10, 0, outcome);
    pay_cycle(1, 2'b10, 0, outcome);
    pay_cycle(1, 2'b10, 0, outcome);
    dispense_phase(DT, 0);

    // Reset mid-DISPENSE
    start(2);
    handshake(0, 0, in_pay);
    pay_cycle(1, 2'b10, 0, outcome);
    pay_cycle(1, 2'b10, 0, outcome);
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_en", product_dispense_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_credit", credit, 0);
    check("mid_rst_price", price, 0);
    check("mid_rst_product", selected_product, 0);
    check("mid_rst_change", change_valid, 0);
    check("mid_rst_amount", change_amount, 0);
    tick();
    check("mid_rst_no_change", change_valid, 0);
    start(3);
    handshake(0, 1, in_pay);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        r = $urandom_range(0, 3);
        coin_valid = (r == 0); coin_value = 2'($urandom_range(0, 3));
        cancel = (r == 1);
        select_req = (r == 2); product_sel = 2'b00;
        tick();
        clear_inputs();
        check("idle_busy", busy, 0);
        check("idle_reject", coin_reject, r == 0);
      end
      p = $urandom_range(1, 3);
      start(p);
      handshake($urandom_range(0, 2), $urandom_range(0, 7) == 0, in_pay);
      if (in_pay) begin
        outcome = 0;
        for (int c = 0; c < 100 && outcome == 0; c++) begin
          r = $urandom_range(0, 9);
          if (r <= 4)
            pay_cycle(1, 2'($urandom_range(1, 2)), 0, outcome);
          else if (r == 5)
            pay_cycle(1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 0, outcome);
          else if (r == 6 && $urandom_range(0, 3) == 0)
            pay_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(1, 2)), 1, outcome);
          else
            pay_cycle(0, 2'b00, 0, outcome);
        end
        if (outcome == 1) dispense_phase($urandom_range(0, DT), 1);
        else finish_change();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
